multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I-subset datapath: register file, ALU/arith, immediate/branch/jump generation and the shared instruction/data memory.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives PC, IR, register-file and memory enables, the ALU op and operand select, writeback select and next-PC select.
- Arbitrates the single memory port between instruction fetch and load/store, using a req/ready handshake with timeout.

Parameters:
- TIMEOUT, 255: max cycles mem_req may wait for mem_ready before bus error. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ins  in  32  instruction from IR, valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- pc_we  out  1  PC register write enable
- ir_we  out  1  IR load enable
- mem_req  out  1  memory request
- mem_we  out  1  memory write (store)
- reg_we  out  1  register-file write enable
- alu_op  out  3  ALU op: 000 and, 001 or, 010 add, 110 sub, 111 slt
- alu_src  out  1  0 = rd2, 1 = immediate
- wb_sel  out  2  00 ALU result, 01 memory data, 10 PC+4
- pc_sel  out  2  00 PC+4, 01 branch target, 10 jal target
- state  out  3  current state, for debug
- illegal  out  1  illegal instruction trap
- bus_err  out  1  memory timeout trap
- instret  out  CNT_W  retired-instruction count

Behaviour:
- State encoding: IDLE 000, FETCH 001, DECODE 010, EXEC 011, MEM 100, WB 101, TRAP 111. The state register is clocked.
- Outputs are combinational from state, the latched instruction class, mem_ready and zero.
- Reset:
  - rst_n low forces state = IDLE, instret = 0, class = NONE, wait counter = 0, illegal = 0, bus_err = 0.
  - All outputs are 0 in IDLE.
  - Reset takes effect mid-instruction immediately: no partial write is completed.
- IDLE: go to FETCH on the next edge.
- FETCH:
  - mem_req = 1, mem_we = 0.
  - When mem_ready = 1: ir_we = 1 in that cycle, next state DECODE. Otherwise stay in FETCH.
- DECODE: latch the class from ins[6:0], funct3 = ins[14:12] and ins[30].
  - 0110011 R: funct3 000 gives add (ins[30] = 0) or sub (ins[30] = 1); 111 and; 110 or; 010 slt.
  - 0010011 I: 000 addi, 111 andi, 110 ori, 010 slti. ins[30] is ignored.
  - 0000011 LW (funct3 010); 0100011 SW (funct3 010); 1100011 BEQ (funct3 000); 1101111 JAL.
  - Any other opcode/funct3 combination: next state TRAP, illegal = 1. Otherwise next state EXEC.
- EXEC: alu_op is add for LW/SW and sub for BEQ.
  - R: alu_src = 0, next state WB.
  - I, LW, SW: alu_src = 1. I goes to WB; LW and SW go to MEM.
  - BEQ: alu_src = 0, pc_we = 1, pc_sel = 01 if zero else 00, next state FETCH.
  - JAL: reg_we = 1, wb_sel = 10, pc_we = 1, pc_sel = 10, next state FETCH.
- MEM: mem_req = 1, mem_we = 1 for SW, alu_op held at add.
  - On mem_ready, LW: next state WB.
  - On mem_ready, SW: pc_we = 1, pc_sel = 00, next state FETCH.
- WB: reg_we = 1, wb_sel = 01 for LW else 00, alu_op/alu_src held from EXEC, pc_we = 1, pc_sel = 00, next state FETCH.
- reg_we is asserted even when rd = x0; the register file ignores x0 writes.
- Retirement: instret increments by 1 on every edge where pc_we = 1 and wraps modulo 2^CNT_W.
- Wait counter:
  - Clears on entry to FETCH/MEM and on mem_ready.
  - Increments each cycle mem_req = 1 and mem_ready = 0.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT with mem_ready still 0: next state TRAP, bus_err = 1.
  - mem_ready in the same cycle as the timeout wins: there is no trap.
- TRAP:
  - All enables are 0; illegal/bus_err stay high until reset.
  - mem_ready and zero are ignored.
  - instret is frozen.
- Latency with mem_ready tied high: R/I 4 cycles, SW 4, LW 5, BEQ 3, JAL 3.
- mem_ready outside FETCH/MEM is ignored. mem_req never asserts in DECODE/EXEC/WB, so fetch and data accesses are exclusive.

Test Plan:
- Reset, then add x3,x1,x2 (0x002081B3), mem_ready = 1:
  - state sequence 000, 001, 010, 011, 101, 001.
  - ir_we pulses in FETCH; EXEC alu_op = 010, alu_src = 0; WB reg_we = 1, wb_sel = 00.
  - instret = 1.
- lw x5,8(x1) (0x0080A283) with mem_ready low for 3 cycles in MEM:
  - mem_req held for 4 cycles; WB has wb_sel = 01, reg_we = 1.
  - 8 cycles total; instret increments once.
- beq (0x00208463), zero = 1 then zero = 0:
  - EXEC alu_op = 110; pc_sel = 01 with zero = 1, 00 with zero = 0; pc_we = 1 in both cases.
  - 3 cycles each.
- jal x1 (0x008000EF):
  - EXEC reg_we = 1, wb_sel = 10, pc_sel = 10, pc_we = 1; next state FETCH.
- Opcode 0x0000007F:
  - DECODE goes to TRAP (111), illegal = 1.
  - All enables stay 0 for 20 cycles; rst_n pulse returns the block to IDLE with illegal = 0.
- TIMEOUT = 4, mem_ready held 0 in FETCH:
  - TRAP with bus_err = 1 after the 4th wait cycle.
  - Repeat with mem_ready = 1 in that same cycle: DECODE, no trap.
  - Assert rst_n low during MEM of a SW: mem_we drops immediately and instret is unchanged (0).

Source files
------------

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control/memory bus between multicycle_ctrl and the RV32I datapath
interface multicycle_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      ins;
  logic             zero;
  logic             mem_ready;
  logic             pc_we;
  logic             ir_we;
  logic             mem_req;
  logic             mem_we;
  logic             reg_we;
  logic [2:0]       alu_op;
  logic             alu_src;
  logic [1:0]       wb_sel;
  logic [1:0]       pc_sel;
  logic [2:0]       state;
  logic             illegal;
  logic             bus_err;
  logic [CNT_W-1:0] instret;

  modport master (
    input  ins, zero, mem_ready,
    output pc_we, ir_we, mem_req, mem_we, reg_we, alu_op, alu_src,
           wb_sel, pc_sel, state, illegal, bus_err, instret
  );

  modport slave (
    output ins, zero, mem_ready,
    input  pc_we, ir_we, mem_req, mem_we, reg_we, alu_op, alu_src,
           wb_sel, pc_sel, state, illegal, bus_err, instret
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM for an RV32I subset
module multicycle_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FETCH  = 3'b001,
    S_DECODE = 3'b010,
    S_EXEC   = 3'b011,
    S_MEM    = 3'b100,
    S_WB     = 3'b101,
    S_TRAP   = 3'b111
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL
  } cls_t;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state_q, state_d;
  cls_t             cls_q, dec_cls;
  logic [2:0]       op_q, dec_op;
  logic [WAIT_W-1:0] wait_q;
  logic             illegal_q, bus_err_q;
  logic [CNT_W-1:0] instret_q;

  logic       pc_we, ir_we, mem_req, mem_we, reg_we, alu_src;
  logic [2:0] alu_op;
  logic [1:0] wb_sel, pc_sel;
  logic       set_ill, set_bus, timeout_hit;

  logic [2:0] f3;
  logic       unused_ins;
  assign f3         = bus.ins[14:12];
  assign unused_ins = ^{bus.ins[31], bus.ins[29:15], bus.ins[11:7]};

  // Wait counter reaching TIMEOUT on this edge with mem_ready still low.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_LAST) && !bus.mem_ready;

  always_comb begin
    dec_cls = C_NONE;
    dec_op  = OP_ADD;
    case (bus.ins[6:0])
      7'b0110011: begin
        dec_cls = C_R;
        case (f3)
          3'b000:  dec_op = bus.ins[30] ? OP_SUB : OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_cls = C_NONE;
        endcase
      end
      7'b0010011: begin
        dec_cls = C_I;
        case (f3)
          3'b000:  dec_op = OP_ADD;
          3'b111:  dec_op = OP_AND;
          3'b110:  dec_op = OP_OR;
          3'b010:  dec_op = OP_SLT;
          default: dec_cls = C_NONE;
        endcase
      end
      7'b0000011: if (f3 == 3'b010) dec_cls = C_LW;
      7'b0100011: if (f3 == 3'b010) dec_cls = C_SW;
      7'b1100011: if (f3 == 3'b000) dec_cls = C_BEQ;
      7'b1101111: dec_cls = C_JAL;
      default:    dec_cls = C_NONE;
    endcase
  end

  always_comb begin
    state_d = state_q;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    reg_we  = 1'b0;
    alu_op  = OP_AND;
    alu_src = 1'b0;
    wb_sel  = 2'b00;
    pc_sel  = 2'b00;
    set_ill = 1'b0;
    set_bus = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          set_bus = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DECODE: begin
        if (dec_cls == C_NONE) begin
          set_ill = 1'b1;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_R: begin
            alu_op  = op_q;
            state_d = S_WB;
          end
          C_I: begin
            alu_op  = op_q;
            alu_src = 1'b1;
            state_d = S_WB;
          end
          C_LW, C_SW: begin
            alu_op  = OP_ADD;
            alu_src = 1'b1;
            state_d = S_MEM;
          end
          C_BEQ: begin
            alu_op  = OP_SUB;
            pc_we   = 1'b1;
            pc_sel  = bus.zero ? 2'b01 : 2'b00;
            state_d = S_FETCH;
          end
          C_JAL: begin
            reg_we  = 1'b1;
            wb_sel  = 2'b10;
            pc_we   = 1'b1;
            pc_sel  = 2'b10;
            state_d = S_FETCH;
          end
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (cls_q == C_SW);
        alu_op  = OP_ADD;
        alu_src = 1'b1;
        if (bus.mem_ready) begin
          if (cls_q == C_LW) begin
            state_d = S_WB;
          end else begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end else if (timeout_hit) begin
          set_bus = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = (cls_q == C_LW) ? 2'b01 : 2'b00;
        alu_op  = (cls_q == C_R || cls_q == C_I) ? op_q : OP_ADD;
        alu_src = (cls_q != C_R);
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_NONE;
      op_q      <= OP_ADD;
      wait_q    <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) begin
        cls_q <= dec_cls;
        op_q  <= dec_op;
      end
      // Each new memory phase starts with a fresh wait budget.
      if (state_d != state_q && (state_d == S_FETCH || state_d == S_MEM))
        wait_q <= '0;
      else if (mem_req && bus.mem_ready)
        wait_q <= '0;
      else if (mem_req)
        wait_q <= wait_q + 1'b1;
      if (set_ill) illegal_q <= 1'b1;
      if (set_bus) bus_err_q <= 1'b1;
      if (pc_we)   instret_q <= instret_q + 1'b1;
    end
  end

  assign bus.pc_we   = pc_we;
  assign bus.ir_we   = ir_we;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.reg_we  = reg_we;
  assign bus.alu_op  = alu_op;
  assign bus.alu_src = alu_src;
  assign bus.wb_sel  = wb_sel;
  assign bus.pc_sel  = pc_sel;
  assign bus.state   = state_q;
  assign bus.illegal = illegal_q;
  assign bus.bus_err = bus_err_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed scoreboard bench for multicycle_ctrl
module tb_multicycle_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  multicycle_ctrl_if #(.CNT_W(32)) bus();
  multicycle_ctrl #(.TIMEOUT(4), .CNT_W(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  localparam logic [2:0] IDLE = 3'b000, FETCH = 3'b001, DECODE = 3'b010, EXEC = 3'b011;
  localparam logic [2:0] MEM = 3'b100, WB = 3'b101, TRAP = 3'b111;
  localparam logic [2:0] ADD = 3'b010, SUB = 3'b110, ORR = 3'b001;
  localparam logic [1:0] OK = 2'b00, ILL = 2'b10, BUS = 2'b01;

  typedef struct {
    string       tag;
    logic [2:0]  st;
    logic [12:0] ctl;
    logic [1:0]  flg;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // {pc_we, ir_we, mem_req, mem_we, reg_we, alu_op, alu_src, wb_sel, pc_sel}
  function automatic logic [12:0] c(input logic pw, iw, mr, mw, rw, input logic [2:0] op,
                                    input logic src, input logic [1:0] wb, ps);
    return {pw, iw, mr, mw, rw, op, src, wb, ps};
  endfunction

  localparam logic [12:0] NONE = 13'b0;
  logic [12:0] f1, f0;

  task automatic compare_front();
    exp_t e;
    logic [12:0] got;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty got=0 entries exp>=1");
      return;
    end
    e = sb.pop_front();
    got = {bus.pc_we, bus.ir_we, bus.mem_req, bus.mem_we, bus.reg_we, bus.alu_op,
           bus.alu_src, bus.wb_sel, bus.pc_sel};
    assert (bus.state === e.st) else begin
      errors++;
      $error("FAIL %s state got=%b exp=%b", e.tag, bus.state, e.st);
    end
    checks++;
    assert (got === e.ctl) else begin
      errors++;
      $error("FAIL %s ctl got=%b exp=%b", e.tag, got, e.ctl);
    end
    checks++;
    assert ({bus.illegal, bus.bus_err} === e.flg) else begin
      errors++;
      $error("FAIL %s flags got=%b exp=%b", e.tag, {bus.illegal, bus.bus_err}, e.flg);
    end
  endtask

  task automatic step(input string tag, input logic [2:0] st, input logic [12:0] ctl,
                      input logic [1:0] flg);
    exp_t e;
    e.tag = tag; e.st = st; e.ctl = ctl; e.flg = flg;
    sb.push_back(e);
    @(negedge clk);
    compare_front();
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] exp);
    checks++;
    assert (bus.instret === exp) else begin
      errors++;
      $error("FAIL %s instret got=%0d exp=%0d", tag, bus.instret, exp);
    end
  endtask

  initial begin
    exp_t e;
    f1 = c(0, 1, 1, 0, 0, 3'b000, 0, 2'b00, 2'b00);
    f0 = c(0, 0, 1, 0, 0, 3'b000, 0, 2'b00, 2'b00);
    bus.ins = 32'h0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    step("rst_idle", IDLE, NONE, OK);
    check_cnt("rst_cnt", 0);
    rst_n = 1'b1;
    step("idle", IDLE, NONE, OK);

    bus.ins = 32'h002081B3; bus.mem_ready = 1'b1;
    step("add_f", FETCH, f1, OK);
    step("add_d", DECODE, NONE, OK);
    step("add_e", EXEC, c(0, 0, 0, 0, 0, ADD, 0, 2'b00, 2'b00), OK);
    step("add_wb", WB, c(1, 0, 0, 0, 1, ADD, 0, 2'b00, 2'b00), OK);
    check_cnt("add_ret", 1);

    bus.ins = 32'h0080A283;
    step("lw_f", FETCH, f1, OK);
    step("lw_d", DECODE, NONE, OK);
    step("lw_e", EXEC, c(0, 0, 0, 0, 0, ADD, 1, 2'b00, 2'b00), OK);
    bus.mem_ready = 1'b0;
    repeat (3) step("lw_mwait", MEM, c(0, 0, 1, 0, 0, ADD, 1, 2'b00, 2'b00), OK);
    bus.mem_ready = 1'b1;
    step("lw_m", MEM, c(0, 0, 1, 0, 0, ADD, 1, 2'b00, 2'b00), OK);
    step("lw_wb", WB, c(1, 0, 0, 0, 1, ADD, 1, 2'b01, 2'b00), OK);
    check_cnt("lw_ret", 2);

    bus.ins = 32'h00208463; bus.zero = 1'b1;
    step("beq1_f", FETCH, f1, OK);
    step("beq1_d", DECODE, NONE, OK);
    step("beq1_e", EXEC, c(1, 0, 0, 0, 0, SUB, 0, 2'b00, 2'b01), OK);
    check_cnt("beq1_ret", 3);
    bus.zero = 1'b0;
    step("beq0_f", FETCH, f1, OK);
    step("beq0_d", DECODE, NONE, OK);
    step("beq0_e", EXEC, c(1, 0, 0, 0, 0, SUB, 0, 2'b00, 2'b00), OK);
    check_cnt("beq0_ret", 4);

    bus.ins = 32'h008000EF;
    step("jal_f", FETCH, f1, OK);
    step("jal_d", DECODE, NONE, OK);
    step("jal_e", EXEC, c(1, 0, 0, 0, 1, 3'b000, 0, 2'b10, 2'b10), OK);
    check_cnt("jal_ret", 5);

    bus.ins = 32'h0020E193;
    step("ori_f", FETCH, f1, OK);
    step("ori_d", DECODE, NONE, OK);
    step("ori_e", EXEC, c(0, 0, 0, 0, 0, ORR, 1, 2'b00, 2'b00), OK);
    step("ori_wb", WB, c(1, 0, 0, 0, 1, ORR, 1, 2'b00, 2'b00), OK);
    bus.ins = 32'h402081B3;
    step("sub_f", FETCH, f1, OK);
    step("sub_d", DECODE, NONE, OK);
    step("sub_e", EXEC, c(0, 0, 0, 0, 0, SUB, 0, 2'b00, 2'b00), OK);
    step("sub_wb", WB, c(1, 0, 0, 0, 1, SUB, 0, 2'b00, 2'b00), OK);
    check_cnt("sub_ret", 7);

    bus.mem_ready = 1'b0;
    repeat (4) step("to_f", FETCH, f0, OK);
    step("to_trap", TRAP, NONE, BUS);
    bus.mem_ready = 1'b1; bus.zero = 1'b1;
    repeat (3) step("to_hold", TRAP, NONE, BUS);
    check_cnt("to_frozen", 7);
    rst_n = 1'b0;
    step("to_rst", IDLE, NONE, OK);
    rst_n = 1'b1;
    check_cnt("to_rst_cnt", 0);
    step("idle2", IDLE, NONE, OK);

    bus.ins = 32'h0000007F; bus.mem_ready = 1'b0;
    repeat (3) step("race_f", FETCH, f0, OK);
    bus.mem_ready = 1'b1;
    step("race_f4", FETCH, f1, OK);
    step("ill_d", DECODE, NONE, OK);
    for (int i = 0; i < 20; i++) begin
      bus.zero = i[0];
      step("ill_trap", TRAP, NONE, ILL);
    end
    rst_n = 1'b0;
    step("ill_rst", IDLE, NONE, OK);
    rst_n = 1'b1;
    step("idle3", IDLE, NONE, OK);

    bus.ins = 32'h0020A423; bus.mem_ready = 1'b1;
    step("swr_f", FETCH, f1, OK);
    step("swr_d", DECODE, NONE, OK);
    step("swr_e", EXEC, c(0, 0, 0, 0, 0, ADD, 1, 2'b00, 2'b00), OK);
    bus.mem_ready = 1'b0;
    step("swr_m", MEM, c(0, 0, 1, 1, 0, ADD, 1, 2'b00, 2'b00), OK);
    #2;
    e.tag = "swr_async"; e.st = IDLE; e.ctl = NONE; e.flg = OK;
    sb.push_back(e);
    rst_n = 1'b0;
    #1;
    compare_front();
    check_cnt("swr_cnt", 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("idle4", IDLE, NONE, OK);

    bus.mem_ready = 1'b1;
    step("sw_f", FETCH, f1, OK);
    step("sw_d", DECODE, NONE, OK);
    step("sw_e", EXEC, c(0, 0, 0, 0, 0, ADD, 1, 2'b00, 2'b00), OK);
    step("sw_m", MEM, c(1, 0, 1, 1, 0, ADD, 1, 2'b00, 2'b00), OK);
    check_cnt("sw_ret", 1);
    step("sw_next", FETCH, f1, OK);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
